// File: rtl/generador_pulsos_ctrl_if.sv
`default_nettype none
// ============================================================================
// generador_pulsos_ctrl_if : command/status bundle of the pulse-train scheduler
// Revision: 1.0
// ============================================================================
interface generador_pulsos_ctrl_if #(
  parameter int W = 5,
  parameter int N = 4
);
  logic         i_start;
  logic [W-1:0] i_periodo;
  logic [W-1:0] i_alto;
  logic [N-1:0] i_n_pulsos;
  logic         i_abort;
  logic         o_ctrl;
  logic         o_busy;
  logic         o_done;
  logic [N-1:0] o_pulse_cnt;

  modport master (
    output i_start, i_periodo, i_alto, i_n_pulsos, i_abort,
    input  o_ctrl, o_busy, o_done, o_pulse_cnt
  );

  modport slave (
    input  i_start, i_periodo, i_alto, i_n_pulsos, i_abort,
    output o_ctrl, o_busy, o_done, o_pulse_cnt
  );
endinterface
`default_nettype wire

// File: rtl/generador_pulsos_ctrl.sv
`default_nettype none
// ============================================================================
// generador_pulsos_ctrl : start/abort controlled scheduler of a periodic o_ctrl train
// Revision: 1.0
// ============================================================================
module generador_pulsos_ctrl #(
  parameter int W = 5,
  parameter int N = 4
) (
  input  wire logic              clock,
  input  wire logic              reset,
  generador_pulsos_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] periodo_q, periodo_d;
  logic [W-1:0] alto_q, alto_d;
  logic [N-1:0] n_pulsos_q, n_pulsos_d;
  logic [W-1:0] k_q, k_d;
  logic [N-1:0] pulse_cnt_q, pulse_cnt_d;
  logic         ctrl_q, ctrl_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic         period_end;
  logic [W-1:0] k_inc;
  logic [N-1:0] cnt_inc;

  assign period_end = (k_q == (periodo_q - W'(1)));
  assign k_inc      = k_q + W'(1);
  assign cnt_inc    = pulse_cnt_q + N'(1);

  always_comb begin
    state_d     = state_q;
    periodo_d   = periodo_q;
    alto_d      = alto_q;
    n_pulsos_d  = n_pulsos_q;
    k_d         = k_q;
    pulse_cnt_d = pulse_cnt_q;
    ctrl_d      = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Abort beats a simultaneous start: nothing is latched.
        if (bus.i_start && !bus.i_abort) begin
          periodo_d   = bus.i_periodo;
          alto_d      = bus.i_alto;
          n_pulsos_d  = bus.i_n_pulsos;
          k_d         = '0;
          pulse_cnt_d = '0;
          if ((bus.i_periodo == '0) || (bus.i_n_pulsos == '0)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
            ctrl_d  = (bus.i_alto != '0);
          end
        end
      end

      ST_RUN: begin
        if (period_end) begin
          k_d         = '0;
          pulse_cnt_d = cnt_inc;
        end else begin
          k_d = k_inc;
        end
        // An abort landing on a period boundary still credits that full period.
        if (bus.i_abort || (period_end && (cnt_inc == n_pulsos_q))) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
          ctrl_d = (k_d < alto_q);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      periodo_q   <= '0;
      alto_q      <= '0;
      n_pulsos_q  <= '0;
      k_q         <= '0;
      pulse_cnt_q <= '0;
      ctrl_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      periodo_q   <= periodo_d;
      alto_q      <= alto_d;
      n_pulsos_q  <= n_pulsos_d;
      k_q         <= k_d;
      pulse_cnt_q <= pulse_cnt_d;
      ctrl_q      <= ctrl_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.o_ctrl      = ctrl_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_pulse_cnt = pulse_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_generador_pulsos_ctrl.sv
`default_nettype none
// ============================================================================
// tb_generador_pulsos_ctrl : directed + random stimulus against a timeline model
// Revision: 1.0
// ============================================================================
module tb_generador_pulsos_ctrl;
  localparam int W = 5;
  localparam int N = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  generador_pulsos_ctrl_if #(.W(W), .N(N)) bus ();

  generador_pulsos_ctrl #(.W(W), .N(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
    end
  endtask

  // Model: a train is a start cycle plus (P,H,C); outputs in cycle c follow
  // from d = c - t0 by division/modulo. m_stop is the cycle showing o_done.
  bit m_valid = 0;
  bit m_train = 0;
  int m_t0, m_p, m_h, m_c, m_stop, m_scnt;

  always @(negedge clock) begin
    int e_ctrl, e_busy, e_done, e_cnt, d;
    if (m_valid) begin
      e_ctrl = 0; e_busy = 0; e_done = 0; e_cnt = 0;
      if (m_train) begin
        d = cyc - m_t0;
        if (cyc < m_stop) begin
          e_busy = 1;
          e_ctrl = ((d % m_p) < m_h) ? 1 : 0;
          e_cnt  = d / m_p;
        end else begin
          e_done = (cyc == m_stop) ? 1 : 0;
          e_cnt  = m_scnt;
        end
      end
      chk("m_ctrl", bus.o_ctrl, e_ctrl);
      chk("m_busy", bus.o_busy, e_busy);
      chk("m_done", bus.o_done, e_done);
      chk("m_cnt",  bus.o_pulse_cnt, e_cnt);
    end
    // predict the effect of the inputs sampled at the coming edge
    if (reset) begin
      m_valid = 1;
      m_train = 0;
    end else if (m_valid) begin
      if (!m_train || cyc > m_stop) begin
        if (bus.i_start && !bus.i_abort) begin
          m_train = 1;
          m_t0 = cyc + 1;
          m_p  = int'(bus.i_periodo);
          m_h  = int'(bus.i_alto);
          m_c  = int'(bus.i_n_pulsos);
          if (m_p == 0 || m_c == 0) begin
            m_stop = m_t0;
            m_scnt = 0;
          end else begin
            m_stop = m_t0 + m_c * m_p;
            m_scnt = m_c;
          end
        end
      end else if (bus.i_abort && cyc < m_stop) begin
        m_stop = cyc + 1;
        m_scnt = (cyc + 1 - m_t0) / m_p;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic look();
    @(negedge clock);
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic launch(input int p, input int h, input int c, output int t);
    bus.i_periodo  = W'(p);
    bus.i_alto     = W'(h);
    bus.i_n_pulsos = N'(c);
    bus.i_start    = 1'b1;
    tick();
    bus.i_start    = 1'b0;
    t = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t, t2;
    logic [15:0] pat;
    bus.i_start = 1'b0; bus.i_abort = 1'b0;
    bus.i_periodo = '0; bus.i_alto = '0; bus.i_n_pulsos = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    look();
    chk("rst_ctrl", bus.o_ctrl, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_cnt",  bus.o_pulse_cnt, 0);
    tick(); tick();

    // basic train P=5 H=2 C=3
    launch(5, 2, 3, t);
    pat = {1'b0, 5'b00011, 5'b00011, 5'b00011};
    for (int j = 0; j <= 15; j++) begin
      look();
      chk("basic_ctrl", bus.o_ctrl, pat[j]);
      if (j == 0)  chk("basic_busy0", bus.o_busy, 1);
      if (j == 5)  chk("basic_cnt1", bus.o_pulse_cnt, 1);
      if (j == 10) chk("basic_cnt2", bus.o_pulse_cnt, 2);
      if (j == 14) chk("basic_busy14", bus.o_busy, 1);
      if (j == 14) chk("basic_nodone14", bus.o_done, 0);
      if (j == 15) begin
        chk("basic_done", bus.o_done, 1);
        chk("basic_busy15", bus.o_busy, 0);
        chk("basic_cnt3", bus.o_pulse_cnt, 3);
      end
      tick();
    end
    tick();

    // full duty P=4 H=7 C=2
    launch(4, 7, 2, t);
    for (int j = 0; j <= 8; j++) begin
      look();
      chk("full_ctrl", bus.o_ctrl, (j < 8) ? 1 : 0);
      if (j == 8) begin
        chk("full_done", bus.o_done, 1);
        chk("full_cnt", bus.o_pulse_cnt, 2);
      end
      tick();
    end
    tick();

    // zero high time P=6 H=0 C=2
    launch(6, 0, 2, t);
    for (int j = 0; j <= 12; j++) begin
      look();
      chk("h0_ctrl", bus.o_ctrl, 0);
      if (j == 12) chk("h0_done", bus.o_done, 1);
      tick();
    end
    tick();

    // degenerate C=0
    launch(5, 2, 0, t);
    look();
    chk("c0_done", bus.o_done, 1);
    chk("c0_busy", bus.o_busy, 0);
    chk("c0_ctrl", bus.o_ctrl, 0);
    tick();
    look();
    chk("c0_done_gone", bus.o_done, 0);
    tick(); tick();

    // abort at edge t+7, P=5 H=3 C=4
    launch(5, 3, 4, t);
    goto(t + 6);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    look();
    chk("abort_ctrl", bus.o_ctrl, 0);
    chk("abort_done", bus.o_done, 1);
    chk("abort_cnt", bus.o_pulse_cnt, 1);
    tick();
    look();
    chk("abort_idle_busy", bus.o_busy, 0);
    chk("abort_idle_done", bus.o_done, 0);
    chk("abort_hold_cnt", bus.o_pulse_cnt, 1);
    tick(); tick();

    // ignored start during RUN and DONE, P=3 H=1 C=2
    launch(3, 1, 2, t);
    goto(t + 1);
    bus.i_start = 1'b1;
    bus.i_periodo = W'(9);
    tick();
    bus.i_start = 1'b0;
    for (int j = 2; j <= 5; j++) begin
      look();
      chk("ign_ctrl", bus.o_ctrl, ((j % 3) < 1) ? 1 : 0);
      tick();
    end
    bus.i_start = 1'b1;
    bus.i_periodo = W'(3); bus.i_alto = W'(1); bus.i_n_pulsos = N'(2);
    look();
    chk("ign_done", bus.o_done, 1);
    tick();
    look();
    chk("ign_not_accepted", bus.o_busy, 0);
    tick();
    bus.i_start = 1'b0;
    look();
    chk("ign_accepted", bus.o_busy, 1);
    chk("ign_accepted_cnt", bus.o_pulse_cnt, 0);
    tick();
    goto(t + 8 + 8);

    // reset mid-train at edge t+4, P=5 H=2 C=3
    launch(5, 2, 3, t);
    goto(t + 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.i_start = 1'b1;
    look();
    chk("mrst_ctrl", bus.o_ctrl, 0);
    chk("mrst_busy", bus.o_busy, 0);
    chk("mrst_cnt", bus.o_pulse_cnt, 0);
    tick();
    bus.i_start = 1'b0;
    t2 = cyc;
    look();
    chk("mrst_restart_busy", bus.o_busy, 1);
    tick();
    goto(t2 + 5);
    look();
    chk("mrst_restart_cnt", bus.o_pulse_cnt, 1);
    tick();
    goto(t2 + 17);

    // random phase: inputs change every cycle, including mid-train
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 299) == 0);
      bus.i_start    = ($urandom_range(0, 3) == 0);
      bus.i_abort    = ($urandom_range(0, 29) == 0);
      bus.i_periodo  = W'($urandom_range(0, 9));
      bus.i_alto     = W'($urandom_range(0, 11));
      bus.i_n_pulsos = N'($urandom_range(0, 5));
      tick();
    end
    reset = 1'b0;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    repeat (80) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
